// File: rtl/note_seq_pkg.sv
// Shared types for the note-sequence recogniser: note codes, step match modes,
// FSM states and the pattern-table entry layout.
package note_seq_pkg;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_C    = 3'd1;
  localparam logic [2:0] NOTE_D    = 3'd2;
  localparam logic [2:0] NOTE_E    = 3'd3;
  localparam logic [2:0] NOTE_F    = 3'd4;
  localparam logic [2:0] NOTE_G    = 3'd5;
  localparam logic [2:0] NOTE_A    = 3'd6;
  localparam logic [2:0] NOTE_B    = 3'd7;

  typedef enum logic [1:0] {
    MODE_EXACT   = 2'd0,
    MODE_ANY     = 2'd1,
    MODE_NONREST = 2'd2,
    MODE_REST    = 2'd3
  } step_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  // Layout for the default 3-bit note code; wider notes keep the same field order.
  typedef struct packed {
    logic       en;
    step_mode_t mode;
    logic       care_tone;
    logic       tone;
    logic [2:0] note;
  } pat_entry_t;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/note_seq_pat_table.sv
// NUM_PAT x SEQ_LEN pattern register file: one write port and a combinational
// read of every pattern's entry at a single step index.
module note_seq_pat_table #(
  parameter int NUM_PAT = 4,
  parameter int SEQ_LEN = 6,
  parameter int ENTRY_W = 8,
  parameter int PAT_W   = 2,
  parameter int STEP_W  = 3,
  parameter int CNT_W   = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              we,
  input  logic [PAT_W-1:0]                  wr_pat,
  input  logic [STEP_W-1:0]                 wr_step,
  input  logic [ENTRY_W-1:0]                wr_entry,
  input  logic [CNT_W-1:0]                  rd_step,
  output logic [NUM_PAT-1:0][ENTRY_W-1:0]   rd_entries
);

  logic [ENTRY_W-1:0] mem [NUM_PAT][SEQ_LEN];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PAT; p++) begin
        for (int s = 0; s < SEQ_LEN; s++) begin
          mem[p][s] <= '0;
        end
      end
    end else if (we && (int'(wr_pat) < NUM_PAT) && (int'(wr_step) < SEQ_LEN)) begin
      mem[wr_pat][wr_step] <= wr_entry;
    end
  end

  // Step index SEQ_LEN (sequence complete) reads as an all-zero entry.
  always_comb begin
    for (int p = 0; p < NUM_PAT; p++) begin
      rd_entries[p] = '0;
      if (int'(rd_step) < SEQ_LEN) begin
        rd_entries[p] = mem[p][rd_step[STEP_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/note_seq_matcher.sv
// Programmable note-sequence recogniser: tracks all loaded patterns in parallel
// and narrows a candidate set on every accepted (rising-edge) press.
module note_seq_matcher
  import note_seq_pkg::*;
#(
  parameter int NUM_PAT     = 4,
  parameter int SEQ_LEN     = 6,
  parameter int NOTE_W      = 3,
  parameter int TIMEOUT_CYC = 0,
  localparam int PAT_W      = safe_clog2(NUM_PAT),
  localparam int STEP_W     = safe_clog2(SEQ_LEN),
  localparam int CNT_W      = safe_clog2(SEQ_LEN + 1),
  localparam int ENTRY_W    = NOTE_W + 5,
  localparam int TO_W       = safe_clog2(TIMEOUT_CYC + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               ok,
  input  logic               tone,
  input  logic [NOTE_W-1:0]  note,
  input  logic               cfg_we,
  input  logic [PAT_W-1:0]   cfg_pat,
  input  logic [STEP_W-1:0]  cfg_step,
  input  logic [ENTRY_W-1:0] cfg_entry,
  output logic               finish,
  output logic               match_vld,
  output logic [PAT_W-1:0]   match_id,
  output logic               error,
  output logic               timeout,
  output logic [CNT_W-1:0]   step,
  output logic               cfg_busy
);

  state_t                          state, nxt_state;
  logic                            ok_q;
  logic                            press;
  logic [NUM_PAT-1:0]              cand, nxt_cand, hit;
  logic [CNT_W-1:0]                nxt_step;
  logic [TO_W-1:0]                 idle_cnt, nxt_cnt;
  logic                            nxt_to;
  logic [PAT_W-1:0]                nxt_id;
  logic [NUM_PAT-1:0][ENTRY_W-1:0] entries;

  assign press = ok & ~ok_q;

  note_seq_pat_table #(
    .NUM_PAT (NUM_PAT),
    .SEQ_LEN (SEQ_LEN),
    .ENTRY_W (ENTRY_W),
    .PAT_W   (PAT_W),
    .STEP_W  (STEP_W),
    .CNT_W   (CNT_W)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .we         (cfg_we && (state != RUN)),
    .wr_pat     (cfg_pat),
    .wr_step    (cfg_step),
    .wr_entry   (cfg_entry),
    .rd_step    (step),
    .rd_entries (entries)
  );

  // Entry fields, MSB first: en, mode[1:0], care_tone, tone, note.
  always_comb begin
    logic [ENTRY_W-1:0] e;
    logic               note_ok;
    e       = '0;
    note_ok = 1'b0;
    for (int p = 0; p < NUM_PAT; p++) begin
      e = entries[p];
      case (step_mode_t'(e[NOTE_W+3:NOTE_W+2]))
        MODE_EXACT:   note_ok = (note == e[NOTE_W-1:0]);
        MODE_ANY:     note_ok = 1'b1;
        MODE_NONREST: note_ok = (note != '0);
        MODE_REST:    note_ok = (note == '0);
        default:      note_ok = 1'b0;
      endcase
      // The enable bit only qualifies step 0, which is the step read in IDLE.
      hit[p] = note_ok && (!e[NOTE_W+1] || (tone == e[NOTE_W]))
               && ((state != IDLE) || e[NOTE_W+4]);
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cand  = cand;
    nxt_step  = step;
    nxt_cnt   = idle_cnt;
    nxt_to    = timeout;
    if (clear) begin
      nxt_state = IDLE;
      nxt_cand  = '0;
      nxt_step  = '0;
      nxt_cnt   = '0;
      nxt_to    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            nxt_cnt  = '0;
            nxt_cand = hit;
            if (hit == '0) begin
              nxt_state = ERROR;
            end else begin
              nxt_state = RUN;
              nxt_step  = CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (press) begin
            nxt_cnt  = '0;
            nxt_cand = cand & hit;
            if ((cand & hit) == '0) begin
              nxt_state = ERROR;
            end else begin
              nxt_step = step + CNT_W'(1);
              if (step + CNT_W'(1) == CNT_W'(SEQ_LEN)) nxt_state = DONE;
            end
          end else if (TIMEOUT_CYC != 0) begin
            if (int'(idle_cnt) + 1 >= TIMEOUT_CYC) begin
              nxt_state = ERROR;
              nxt_to    = 1'b1;
            end else begin
              nxt_cnt = idle_cnt + TO_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt_id = '0;
    for (int p = NUM_PAT - 1; p >= 0; p--) begin
      if (nxt_cand[p]) nxt_id = PAT_W'(p);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ok_q      <= 1'b0;
      state     <= IDLE;
      cand      <= '0;
      step      <= '0;
      idle_cnt  <= '0;
      finish    <= 1'b0;
      match_vld <= 1'b0;
      match_id  <= '0;
      error     <= 1'b0;
      timeout   <= 1'b0;
      cfg_busy  <= 1'b0;
    end else begin
      ok_q      <= ok;
      state     <= nxt_state;
      cand      <= nxt_cand;
      step      <= nxt_step;
      idle_cnt  <= nxt_cnt;
      finish    <= (nxt_state == DONE) || (nxt_state == ERROR);
      match_vld <= (nxt_state == DONE);
      match_id  <= (nxt_state == DONE) ? nxt_id : '0;
      error     <= (nxt_state == ERROR);
      timeout   <= nxt_to;
      cfg_busy  <= (nxt_state == RUN);
    end
  end

endmodule
